// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer: state encoding and
// buffer word-count helpers.
package mm_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_START,
    ST_WAIT,
    ST_RD,
    ST_LAT,
    ST_OUT
  } mm_state_e;

  // A and B pack four 8-bit elements per word, C packs two 16-bit results.
  function automatic int calc_wa(input int n1, input int m);
    return (n1 * m) / 4;
  endfunction

  function automatic int calc_wb(input int m, input int n2);
    return (m * n2) / 4;
  endfunction

  function automatic int calc_wc(input int n1, input int n2);
    return (n1 * n2) / 2;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int r;
    r = (a > b) ? a : b;
    return (r > c) ? r : c;
  endfunction

  function automatic int addr_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mm_axis_oreg.sv
// Output register stage for the result stream: captures one C word and holds
// data/last stable until the downstream handshake.
module mm_axis_oreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  output logic         y_last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
    end else if (load) begin
      y_data  <= load_data;
      y_valid <= 1'b1;
      y_last  <= load_last;
    end else if (y_valid && ready) begin
      y_valid <= 1'b0;
      y_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer for a matrix-multiply array: loads A/B from an input stream,
// pulses start, waits for done, then streams C words out one at a time.
//
// state    | meaning
// LOAD_A   | accept A words from x stream into A buffer
// LOAD_B   | accept B words from x stream into B buffer
// START    | one-cycle start pulse to the array
// WAIT     | wait for array done
// RD       | read strobe to C buffer
// LAT      | C read data returns, captured into output register
// OUT      | present word on y stream until accepted
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int M  = 8,
  parameter int N1 = 4,
  parameter int N2 = 4,
  localparam int WA   = calc_wa(N1, M),
  localparam int WB   = calc_wb(M, N2),
  localparam int WC   = calc_wc(N1, N2),
  localparam int AW_A = addr_w(WA),
  localparam int AW_B = addr_w(WB),
  localparam int AW_C = addr_w(WC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     x_TDATA,
  input  logic            x_TVALID,
  output logic            x_TREADY,
  input  logic            x_TLAST,
  output logic            a_wr_en,
  output logic [AW_A-1:0] a_wr_addr,
  output logic            b_wr_en,
  output logic [AW_B-1:0] b_wr_addr,
  output logic [31:0]     wr_data,
  output logic            start,
  input  logic            done,
  output logic            c_rd_en,
  output logic [AW_C-1:0] c_rd_addr,
  input  logic [31:0]     c_rd_data,
  output logic [31:0]     y_TDATA,
  output logic            y_TVALID,
  input  logic            y_TREADY,
  output logic            y_TLAST,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(max3(WA, WB, WC)) + 1;
  localparam logic [CW-1:0] WA_LAST = CW'(WA - 1);
  localparam logic [CW-1:0] WB_LAST = CW'(WB - 1);
  localparam logic [CW-1:0] WC_LAST = CW'(WC - 1);

  if ((N1 * M) % 4 != 0) begin : g_bad_a
    $error("mm_seq_ctrl: N1*M must be a multiple of 4");
  end
  if ((M * N2) % 4 != 0) begin : g_bad_b
    $error("mm_seq_ctrl: M*N2 must be a multiple of 4");
  end
  if ((N1 * N2) % 2 != 0) begin : g_bad_c
    $error("mm_seq_ctrl: N1*N2 must be even");
  end

  mm_state_e     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_q, err_nx;
  logic          oreg_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOAD_A;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    err_nx    = err_q;
    x_TREADY  = 1'b0;
    a_wr_en   = 1'b0;
    b_wr_en   = 1'b0;
    start     = 1'b0;
    c_rd_en   = 1'b0;
    oreg_load = 1'b0;
    case (state)
      ST_LOAD_A: begin
        x_TREADY = 1'b1;
        a_wr_en  = x_TVALID;
        if (x_TVALID) begin
          // An early TLAST aborts the frame; the beat itself is still written.
          if (x_TLAST) begin
            err_nx = 1'b1;
            cnt_nx = '0;
          end else if (cnt == WA_LAST) begin
            state_nx = ST_LOAD_B;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        x_TREADY = 1'b1;
        b_wr_en  = x_TVALID;
        if (x_TVALID) begin
          if (cnt == WB_LAST) begin
            state_nx = ST_START;
            cnt_nx   = '0;
            if (!x_TLAST) err_nx = 1'b1;
          end else if (x_TLAST) begin
            state_nx = ST_LOAD_A;
            cnt_nx   = '0;
            err_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      ST_START: begin
        start    = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          state_nx = ST_RD;
          cnt_nx   = '0;
        end
      end
      ST_RD: begin
        c_rd_en  = 1'b1;
        state_nx = ST_LAT;
      end
      ST_LAT: begin
        oreg_load = 1'b1;
        state_nx  = ST_OUT;
      end
      ST_OUT: begin
        if (y_TREADY) begin
          if (cnt == WC_LAST) begin
            state_nx = ST_LOAD_A;
            cnt_nx   = '0;
          end else begin
            state_nx = ST_RD;
            cnt_nx   = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = ST_LOAD_A;
        cnt_nx   = '0;
      end
    endcase
  end

  assign a_wr_addr = cnt[AW_A-1:0];
  assign b_wr_addr = cnt[AW_B-1:0];
  assign c_rd_addr = cnt[AW_C-1:0];
  assign wr_data   = x_TDATA;
  assign busy      = !((state == ST_LOAD_A) && (cnt == '0));
  assign err       = err_q;

  mm_axis_oreg #(.W(32)) u_oreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (oreg_load),
    .load_data (c_rd_data),
    .load_last (cnt == WC_LAST),
    .ready     (y_TREADY),
    .y_data    (y_TDATA),
    .y_valid   (y_TVALID),
    .y_last    (y_TLAST)
  );

endmodule
